// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment display scanner.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEAD = 2'd1,
    ST_SHOW = 2'd2
  } state_t;

  // Active-low cathode patterns, bit order gfedcba.
  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Digit k is a leading zero when it and every digit above it are zero.
  // The rightmost digit is always shown so a value of zero still reads "0".
  function automatic logic lz_blank(input logic [15:0] d, input logic [1:0] k,
                                    input logic en);
    logic z;
    case (k)
      2'd1:    z = (d[15:4]  == 12'h000);
      2'd2:    z = (d[15:8]  == 8'h00);
      2'd3:    z = (d[15:12] == 4'h0);
      default: z = 1'b0;
    endcase
    return en & z;
  endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Bundle between the counter logic and the display scanner.
interface seg_scan_if;
  logic        enable;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  // Source of the value to display; observes the pins.
  modport master (
    output enable, digits, dp_in, blank_lz,
    input  seg, dp, an, frame_done
  );

  // The scanner itself.
  modport slave (
    input  enable, digits, dp_in, blank_lz,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes go dark.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Decode one digit.
  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_controller.sv
// Four-digit 7-segment scanner: per-frame snapshot, dead time between digits,
// optional leading-zero blanking. All outputs are registered.
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DEAD_CYCLES = 500
) (
  input logic       clk,
  input logic       rst,
  seg_scan_if.slave bus
);

  localparam logic [19:0] SLOT_LAST = 20'(REFRESH_DIV - 1);
  localparam logic [19:0] DEAD_LAST = 20'(DEAD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] sh_dig_q, sh_dig_d;
  logic [3:0]  sh_dp_q, sh_dp_d;
  logic        sh_blz_q, sh_blz_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [3:0]  an_q, an_d;
  logic        fd_q, fd_d;

  logic [3:0]  digit_nxt;
  logic [6:0]  seg_dec;
  logic        blank_nxt;

  // Next FSM state, slot counter, digit index and snapshot.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    sh_dig_d = sh_dig_q;
    sh_dp_d  = sh_dp_q;
    sh_blz_d = sh_blz_q;
    fd_d     = 1'b0;
    if (!bus.enable) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      idx_d    = '0;
      sh_dig_d = '0;
      sh_dp_d  = '0;
      sh_blz_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_DEAD;
          cnt_d    = '0;
          idx_d    = '0;
          sh_dig_d = bus.digits;
          sh_dp_d  = bus.dp_in;
          sh_blz_d = bus.blank_lz;
        end
        ST_DEAD: begin
          cnt_d = cnt_q + 20'd1;
          if (cnt_q == DEAD_LAST) state_d = ST_SHOW;
        end
        ST_SHOW: begin
          if (cnt_q == SLOT_LAST) begin
            state_d = ST_DEAD;
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              sh_dig_d = bus.digits;
              sh_dp_d  = bus.dp_in;
              sh_blz_d = bus.blank_lz;
              fd_d     = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 20'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output values follow the state being entered, so the pins change on the
  // same edge as the state.
  assign digit_nxt = sh_dig_d[{idx_d, 2'b00} +: 4];
  assign blank_nxt = lz_blank(sh_dig_d, idx_d, sh_blz_d);

  bcd_to_seg u_dec (
    .bcd_i (digit_nxt),
    .seg_o (seg_dec)
  );

  // Pattern, decimal point and anode for the next cycle.
  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    an_d  = AN_OFF;
    if (state_d != ST_IDLE && !blank_nxt) begin
      seg_d = seg_dec;
      dp_d  = ~sh_dp_d[idx_d];
      if (state_d == ST_SHOW) an_d = ~(4'b0001 << idx_d);
    end
  end

  // State and output registers.
  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      sh_dig_q <= '0;
      sh_dp_q  <= '0;
      sh_blz_q <= 1'b0;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b1;
      an_q     <= AN_OFF;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sh_dig_q <= sh_dig_d;
      sh_dp_q  <= sh_dp_d;
      sh_blz_q <= sh_blz_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
      fd_q     <= fd_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Self-checking bench for seg_scan_controller with REFRESH_DIV=8, DEAD_CYCLES=2.
module tb_seg_scan_controller;

  localparam int RD = 8;
  localparam int DC = 2;

  typedef struct {
    logic [15:0]      digits;
    logic [3:0]       dp_in;
    logic             blz;
    logic [3:0][6:0]  seg;   // expected pattern per slot, index = slot
    logic [3:0][3:0]  an;    // expected anodes during SHOW per slot
    logic [3:0]       dp;    // expected dp per slot
  } vec_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   applied = 0;
  int   miss    = 0;
  vec_t tbl [7];
  exp_t sb [$];

  seg_scan_if bus ();

  seg_scan_controller #(.REFRESH_DIV(RD), .DEAD_CYCLES(DC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    applied++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // At most one anode may be active at any time.
  always @(negedge clk) begin
    if (!rst) check("one_hot_an", 16'($countones(~bus.an) <= 1), 16'd1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    bus.digits   = v.digits;
    bus.dp_in    = v.dp_in;
    bus.blank_lz = v.blz;
  endtask

  task automatic check_off(input string tag);
    check({tag, "_an"},  16'(bus.an),  16'hF);
    check({tag, "_seg"}, 16'(bus.seg), 16'h7F);
    check({tag, "_dp"},  16'(bus.dp),  16'h1);
    check({tag, "_fd"},  16'(bus.frame_done), 16'h0);
  endtask

  // One full frame (4 slots) with expectations queued per cycle.
  task automatic run_frame(input vec_t v, input logic fd_first, input int chg_cycle,
                           input logic [15:0] chg_digits);
    exp_t e, g;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < RD; c++) begin
        if (s * RD + c == chg_cycle) bus.digits = chg_digits;
        e.an  = (c < DC) ? 4'hF : v.an[s];
        e.seg = v.seg[s];
        e.dp  = v.dp[s];
        e.fd  = fd_first && (s == 0) && (c == 0);
        sb.push_back(e);
        tick();
        g = sb.pop_front();
        check($sformatf("an s%0d c%0d", s, c),  16'(bus.an),  16'(g.an));
        check($sformatf("seg s%0d c%0d", s, c), 16'(bus.seg), 16'(g.seg));
        check($sformatf("dp s%0d c%0d", s, c),  16'(bus.dp),  16'(g.dp));
        check($sformatf("fd s%0d c%0d", s, c),  16'(bus.frame_done), 16'(g.fd));
      end
    end
  endtask

  initial begin
    // digits, dp_in, blz, seg{s3,s2,s1,s0}, an{s3..s0}, dp{s3..s0}
    tbl[0] = '{16'h1234, 4'b0000, 1'b0,
               {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001},
               {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'b1111};
    tbl[1] = '{16'h0007, 4'b0000, 1'b1,
               {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000},
               {4'b1111, 4'b1111, 4'b1111, 4'b1110}, 4'b1111};
    tbl[2] = '{16'h0000, 4'b0000, 1'b1,
               {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000},
               {4'b1111, 4'b1111, 4'b1111, 4'b1110}, 4'b1111};
    tbl[3] = '{16'h00A0, 4'b0010, 1'b0,
               {7'b1000000, 7'b1000000, 7'b1111111, 7'b1000000},
               {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'b1101};
    tbl[4] = '{16'h0100, 4'b1111, 1'b1,
               {7'b1111111, 7'b1111001, 7'b1000000, 7'b1000000},
               {4'b1111, 4'b1011, 4'b1101, 4'b1110}, 4'b1000};
    tbl[5] = '{16'h5678, 4'b0000, 1'b0,
               {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000},
               {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'b1111};
    tbl[6] = '{16'h9000, 4'b0101, 1'b1,
               {7'b0010000, 7'b1000000, 7'b1000000, 7'b1000000},
               {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'b1010};

    // Reset held with enable high.
    rst = 1'b1;
    bus.enable = 1'b1;
    apply(tbl[0]);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_off($sformatf("reset%0d", i));
    end
    bus.enable = 1'b0;
    rst = 1'b0;
    tick();
    check_off("idle");

    // Table: two frames each, then disable.
    for (int i = 0; i < 7; i++) begin
      apply(tbl[i]);
      bus.enable = 1'b1;
      run_frame(tbl[i], 1'b0, -1, 16'h0);
      run_frame(tbl[i], 1'b1, -1, 16'h0);
      bus.enable = 1'b0;
      tick();
      check_off($sformatf("dis_v%0d", i));
    end

    // Input change mid-frame is invisible until the next frame.
    apply(tbl[0]);
    bus.enable = 1'b1;
    run_frame(tbl[0], 1'b0, RD + 3, 16'h5678);
    run_frame(tbl[5], 1'b1, -1, 16'h0);

    // Drop enable mid-SHOW, then restart from slot 0 with full dead time.
    bus.enable = 1'b0;
    tick();
    apply(tbl[0]);
    bus.enable = 1'b1;
    for (int i = 0; i < DC + 2; i++) tick();
    check("pre_drop_an", 16'(bus.an), 16'hE);
    bus.enable = 1'b0;
    tick();
    check_off("drop_en");
    bus.enable = 1'b1;
    run_frame(tbl[0], 1'b0, -1, 16'h0);

    // Reset mid-SHOW of slot 0 in the next frame, then restart.
    for (int i = 0; i < DC + 2; i++) tick();
    rst = 1'b1;
    tick();
    check_off("rst_mid");
    rst = 1'b0;
    run_frame(tbl[0], 1'b0, -1, 16'h0);

    bus.enable = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", applied, miss);
    $finish;
  end

endmodule

// File: doc/seg_scan_controller.md
# seg_scan_controller

Time-multiplexes the single shared 7-segment cathode bus across the four digits of the board display. It takes a 4-digit BCD value from the counter logic, snapshots it once per frame to prevent tearing, and drives one anode at a time. A dead-time interval at every digit switch suppresses ghosting. Optional leading-zero blanking is supported. It replaces the fixed single-digit anode tie-off in the top-level button-counter design.

## Interface
- `REFRESH_DIV`, default 100000: clk cycles per digit slot (1 ms at 100 MHz); legal range 4..2^20.
- `DEAD_CYCLES`, default 500: cycles per slot with all anodes off; must satisfy 1 ≤ DEAD_CYCLES < REFRESH_DIV.
- `clk`, in, 1: single system clock. All logic runs on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `enable`, in, 1: scanning runs while high.
- `digits`, in, 16: four BCD digits. `digits[3:0]` is index 0, the rightmost digit, `an[0]`.
- `dp_in`, in, 4: decimal point request per digit, active-high.
- `blank_lz`, in, 1: enables leading-zero blanking.
- `seg`, out, 7: cathodes gfedcba, active-low.
- `dp`, out, 1: decimal point cathode, active-low.
- `an`, out, 4: anodes, active-low, at most one low at any time.
- `frame_done`, out, 1: one-cycle pulse at each frame boundary.

## Operation
- States: IDLE, DEAD, SHOW. Slot counter is 20 bits. Digit index `idx` is 2 bits.
- Reset and IDLE values: `an`=4'b1111, `seg`=7'b1111111, `dp`=1, `frame_done`=0, `idx`=0, slot counter=0, shadow=0.
- IDLE→DEAD on the edge where `enable`=1. On that edge:
  - `idx` is set to 0.
  - The shadow registers load `digits`, `dp_in` and `blank_lz`.
- DEAD:
  - Lasts DEAD_CYCLES cycles.
  - `an`=4'b1111.
  - `seg` and `dp` already carry the pattern for the current `idx`.
- DEAD→SHOW when the slot counter reaches DEAD_CYCLES-1.
- SHOW:
  - Lasts REFRESH_DIV-DEAD_CYCLES cycles.
  - `an[idx]`=0 unless the digit is blanked; a blanked digit keeps `an`=4'b1111 and `seg`=7'b1111111.
- SHOW→DEAD when the slot counter reaches REFRESH_DIV-1:
  - `idx` increments and wraps 3→0.
  - On the 3→0 wrap, the shadow reloads from the inputs and `frame_done` pulses high on the same edge, for one cycle.
- `enable`=0 in any state: IDLE on the next edge, with outputs at their reset values. Re-enabling restarts at `idx` 0 in DEAD.
- `rst` has priority over `enable` in all states.
- Decode:
  - BCD values 0–9 map to standard active-low patterns: 0=1000000, 1=1111001, 4=0011001, 7=1111000, 8=0000000.
  - Codes 10–15 give `seg`=7'b1111111, with the anode still driven.
- Leading-zero blanking (shadow `blank_lz`=1):
  - Digit k (k=3..1) is blanked if it is 0 and every higher digit is 0.
  - Digit 0 is never blanked.
  - A blanked digit's `dp` is also forced to 1.
- Inputs change only the display at a frame boundary; mid-frame changes are invisible.

## Timing
- Outputs `seg`, `dp`, `an` and `frame_done` are flops, taking their new state's values on the transition edge. There is no combinational path from input to output.
- Latency from the edge that samples `enable`=1 to the first active anode is DEAD_CYCLES+1 edges.
- Slot period is exactly REFRESH_DIV cycles. Frame period is 4·REFRESH_DIV cycles. The `frame_done` period is 4·REFRESH_DIV.
- The `an` value is never low on two bits at once, and every change of `an` between digits passes through 4'b1111 for ≥ DEAD_CYCLES cycles.

## Structure
- Shared package `seg_pkg`:
  - State enum.
  - Active-low segment constants SEG_0..SEG_9 and SEG_OFF.
  - AN_OFF = 4'b1111.
- One sub-module, `bcd_to_seg`: combinational BCD→active-low pattern, with default SEG_OFF.
- `seg_scan_controller` owns the FSM, slot counter, index, shadow registers, blanking logic and output flops.

## Test plan
Bench parameters: REFRESH_DIV=8, DEAD_CYCLES=2.
- Hold `rst` 3 cycles with `enable`=1 → `an`=1111, `seg`=1111111, `dp`=1, `frame_done`=0 throughout.
- `digits`=16'h1234, `dp_in`=0, raise `enable` →
  - 2 cycles of `an`=1111.
  - 6 cycles of `an`=1110 with `seg`=0011001.
  - Then 2 cycles off and 6 cycles of `an`=1101 with `seg`=0110000.
  - `frame_done` pulses once every 32 cycles.
- `digits`=16'h0007, `blank_lz`=1 → slots 1–3 have `an`=1111 and `seg`=1111111; slot 0 shows 1111000. With `digits`=16'h0000, slot 0 shows 1000000.
- Change `digits` from 16'h1234 to 16'h5678 during slot 1 → the rest of the frame still shows 3, 2, 1. The next frame, after `frame_done`, shows 8 in slot 0.
- Drop `enable` mid-SHOW → next edge gives `an`=1111 and `seg`=1111111. Re-raise `enable` → restart at slot 0 with the full dead time. Assert `rst` mid-SHOW → same result, `idx`=0.
- `digits`=16'h00A0 with `dp_in`=4'b0010 → slot 1 has `an`=1101, `seg`=1111111, `dp`=0. The assertion "`an` is never low on more than 1 bit" holds for the whole run.
